// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//   Decode half of the 5-stage pipeline. Decodes the 4-bit opcode into datapath
//   control, extends the immediate field, and registers everything (plus the
//   register-file read operands and the destination index) into the ID/EX
//   pipeline register. One cycle of latency, no enable.
//
// Optional build macro: ID_EX_FLUSH_EN
//   When defined, adds Flush_i. A clock edge with Flush_i = 1 loads a bubble:
//   the state-changing controls (RF_WE, BranchSelect, SetFlags, MemWE) load 0,
//   all other fields load normally. RST has priority over Flush_i.
//
// Ports
//   CLK            pipeline clock, rising edge
//   RST            asynchronous active-high reset, clears the whole register
//   Flush_i        (ID_EX_FLUSH_EN only) load a bubble on this edge
//   Instr_i        instruction: [31:28] opcode, [27:24] A1, [23:20] A2,
//                  [19:16] A3, [19:0] immediate field
//   RD1_i/RD2_i    register-file read data (N bits)
//   RD1_o/RD2_o    registered read data
//   Extend_o       registered extended immediate
//   A3_o           registered destination index
//   RF_WE_o, BranchSelect_o, ALUOpBSelect_o, ALUControl_o, SetFlags_o,
//   MemWE_o, WBSelect_o   registered decoded controls
// -----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int N = 32
) (
    input  logic         CLK,
    input  logic         RST,
`ifdef ID_EX_FLUSH_EN
    input  logic         Flush_i,
`endif
    input  logic [31:0]  Instr_i,
    input  logic [N-1:0] RD1_i,
    input  logic [N-1:0] RD2_i,
    output logic [N-1:0] RD1_o,
    output logic [N-1:0] RD2_o,
    output logic [N-1:0] Extend_o,
    output logic [3:0]   A3_o,
    output logic         RF_WE_o,
    output logic         BranchSelect_o,
    output logic         ALUOpBSelect_o,
    output logic [1:0]   ALUControl_o,
    output logic         SetFlags_o,
    output logic         MemWE_o,
    output logic         WBSelect_o
);

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_B    = 4'b0001;
    localparam logic [3:0] OP_LDR  = 4'b0100;
    localparam logic [3:0] OP_STR  = 4'b0101;
    localparam logic [3:0] OP_ADD  = 4'b1000;
    localparam logic [3:0] OP_ADDI = 4'b1001;
    localparam logic [3:0] OP_SUB  = 4'b1010;
    localparam logic [3:0] OP_SUBI = 4'b1011;
    localparam logic [3:0] OP_AND  = 4'b1100;
    localparam logic [3:0] OP_ORR  = 4'b1101;
    localparam logic [3:0] OP_CMP  = 4'b1110;

    localparam logic [1:0] EXT_ZE16 = 2'b00;
    localparam logic [1:0] EXT_SE16 = 2'b01;
    localparam logic [1:0] EXT_SE20 = 2'b10;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    // A1/A2 only address the external register file.
    logic unused_addr_fields;
    assign unused_addr_fields = ^Instr_i[27:20];

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [3:0] opcode;
    logic       dec_rf_we, dec_branch, dec_opb_sel, dec_set_flags;
    logic       dec_mem_we, dec_wb_sel;
    logic [1:0] dec_alu_ctrl, ext_sel;

    assign opcode = Instr_i[31:28];

    always_comb begin
        dec_rf_we     = 1'b0;
        dec_branch    = 1'b0;
        dec_opb_sel   = 1'b0;
        dec_alu_ctrl  = ALU_ADD;
        dec_set_flags = 1'b0;
        dec_mem_we    = 1'b0;
        dec_wb_sel    = 1'b0;
        ext_sel       = EXT_ZE16;
        unique case (opcode)
            OP_B: begin
                dec_branch  = 1'b1;
                dec_opb_sel = 1'b1;
                ext_sel     = EXT_SE20;
            end
            OP_LDR: begin
                dec_rf_we   = 1'b1;
                dec_opb_sel = 1'b1;
                dec_wb_sel  = 1'b1;
            end
            OP_STR: begin
                dec_opb_sel = 1'b1;
                dec_mem_we  = 1'b1;
            end
            OP_ADD: dec_rf_we = 1'b1;
            OP_ADDI: begin
                dec_rf_we   = 1'b1;
                dec_opb_sel = 1'b1;
                ext_sel     = EXT_SE16;
            end
            OP_SUB: begin
                dec_rf_we    = 1'b1;
                dec_alu_ctrl = ALU_SUB;
            end
            OP_SUBI: begin
                dec_rf_we    = 1'b1;
                dec_opb_sel  = 1'b1;
                dec_alu_ctrl = ALU_SUB;
                ext_sel      = EXT_SE16;
            end
            OP_AND: begin
                dec_rf_we    = 1'b1;
                dec_alu_ctrl = ALU_AND;
            end
            OP_ORR: begin
                dec_rf_we    = 1'b1;
                dec_alu_ctrl = ALU_ORR;
            end
            OP_CMP: begin
                dec_alu_ctrl  = ALU_SUB;
                dec_set_flags = 1'b1;
            end
            default: ; // NOP and unused opcodes keep the all-zero defaults
        endcase
    end

    // ------------------------------------------------------------------
    // Immediate extension. Filling with the sign bit first and then
    // overwriting the low field works for any N >= 20 without a
    // zero-width replication.
    // ------------------------------------------------------------------
    logic [N-1:0] extend_d;

    always_comb begin
        extend_d = '0;
        case (ext_sel)
            EXT_ZE16: extend_d[15:0] = Instr_i[15:0];
            EXT_SE16: begin
                extend_d       = {N{Instr_i[15]}};
                extend_d[15:0] = Instr_i[15:0];
            end
            EXT_SE20: begin
                extend_d       = {N{Instr_i[19]}};
                extend_d[19:0] = Instr_i[19:0];
            end
            default: extend_d = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state for the ID/EX register
    // ------------------------------------------------------------------
    logic bubble;

`ifdef ID_EX_FLUSH_EN
    assign bubble = Flush_i;
`else
    assign bubble = 1'b0;
`endif

    logic [N-1:0] rd1_d, rd2_d;
    logic [3:0]   a3_d;
    logic         rf_we_d, branch_d, opb_sel_d, set_flags_d, mem_we_d, wb_sel_d;
    logic [1:0]   alu_ctrl_d;

    always_comb begin
        rd1_d       = RD1_i;
        rd2_d       = RD2_i;
        a3_d        = Instr_i[19:16];
        opb_sel_d   = dec_opb_sel;
        alu_ctrl_d  = dec_alu_ctrl;
        wb_sel_d    = dec_wb_sel;
        // A bubble only has to suppress architectural side effects.
        rf_we_d     = dec_rf_we     & ~bubble;
        branch_d    = dec_branch    & ~bubble;
        set_flags_d = dec_set_flags & ~bubble;
        mem_we_d    = dec_mem_we    & ~bubble;
    end

    logic [N-1:0] rd1_q, rd2_q, extend_q;
    logic [3:0]   a3_q;
    logic         rf_we_q, branch_q, opb_sel_q, set_flags_q, mem_we_q, wb_sel_q;
    logic [1:0]   alu_ctrl_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd1_q       <= '0;
            rd2_q       <= '0;
            extend_q    <= '0;
            a3_q        <= '0;
            rf_we_q     <= 1'b0;
            branch_q    <= 1'b0;
            opb_sel_q   <= 1'b0;
            alu_ctrl_q  <= 2'b00;
            set_flags_q <= 1'b0;
            mem_we_q    <= 1'b0;
            wb_sel_q    <= 1'b0;
        end else begin
            rd1_q       <= rd1_d;
            rd2_q       <= rd2_d;
            extend_q    <= extend_d;
            a3_q        <= a3_d;
            rf_we_q     <= rf_we_d;
            branch_q    <= branch_d;
            opb_sel_q   <= opb_sel_d;
            alu_ctrl_q  <= alu_ctrl_d;
            set_flags_q <= set_flags_d;
            mem_we_q    <= mem_we_d;
            wb_sel_q    <= wb_sel_d;
        end
    end

    assign RD1_o          = rd1_q;
    assign RD2_o          = rd2_q;
    assign Extend_o       = extend_q;
    assign A3_o           = a3_q;
    assign RF_WE_o        = rf_we_q;
    assign BranchSelect_o = branch_q;
    assign ALUOpBSelect_o = opb_sel_q;
    assign ALUControl_o   = alu_ctrl_q;
    assign SetFlags_o     = set_flags_q;
    assign MemWE_o        = mem_we_q;
    assign WBSelect_o     = wb_sel_q;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    localparam int N = 32;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [31:0]  Instr_i = '0;
    logic [N-1:0] RD1_i = '0, RD2_i = '0;
    logic [N-1:0] RD1_o, RD2_o, Extend_o;
    logic [3:0]   A3_o;
    logic         RF_WE_o, BranchSelect_o, ALUOpBSelect_o, SetFlags_o, MemWE_o, WBSelect_o;
    logic [1:0]   ALUControl_o;
`ifdef ID_EX_FLUSH_EN
    logic         Flush_i = 1'b0;
`endif

    id_ex_stage #(.N(N)) dut (
        .CLK            (CLK),
        .RST            (RST),
`ifdef ID_EX_FLUSH_EN
        .Flush_i        (Flush_i),
`endif
        .Instr_i        (Instr_i),
        .RD1_i          (RD1_i),
        .RD2_i          (RD2_i),
        .RD1_o          (RD1_o),
        .RD2_o          (RD2_o),
        .Extend_o       (Extend_o),
        .A3_o           (A3_o),
        .RF_WE_o        (RF_WE_o),
        .BranchSelect_o (BranchSelect_o),
        .ALUOpBSelect_o (ALUOpBSelect_o),
        .ALUControl_o   (ALUControl_o),
        .SetFlags_o     (SetFlags_o),
        .MemWE_o        (MemWE_o),
        .WBSelect_o     (WBSelect_o)
    );

    always #5 CLK = ~CLK;

    // Control byte: [7] RF_WE [6] Branch [5] OpBSel [4:3] ALUCtl [2] SetFlags [1] MemWE [0] WBSel
    typedef struct {
        logic [N-1:0] rd1;
        logic [N-1:0] rd2;
        logic [N-1:0] ext;
        logic [3:0]   a3;
        logic [7:0]   ctrl;
    } exp_t;

    typedef struct {
        string        name;
        logic [31:0]  instr;
        logic [N-1:0] rd1;
        logic [N-1:0] rd2;
        exp_t         exp;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic exp_t actual();
        exp_t a;
        a.rd1  = RD1_o;
        a.rd2  = RD2_o;
        a.ext  = Extend_o;
        a.a3   = A3_o;
        a.ctrl = {RF_WE_o, BranchSelect_o, ALUOpBSelect_o, ALUControl_o,
                  SetFlags_o, MemWE_o, WBSelect_o};
        return a;
    endfunction

    task automatic check(input string name, input exp_t e);
        exp_t a;
        a = actual();
        n_checks++;
        if (a.rd1 !== e.rd1 || a.rd2 !== e.rd2 || a.ext !== e.ext ||
            a.a3 !== e.a3 || a.ctrl !== e.ctrl) begin
            n_fail++;
            $display("FAIL %s: got rd1=%h rd2=%h ext=%h a3=%h ctrl=%b, expected rd1=%h rd2=%h ext=%h a3=%h ctrl=%b",
                     name, a.rd1, a.rd2, a.ext, a.a3, a.ctrl,
                     e.rd1, e.rd2, e.ext, e.a3, e.ctrl);
        end
    endtask

    // Reference model: instruction semantics from the opcode table, extension by
    // signed/unsigned integer arithmetic.
    function automatic exp_t model(input logic [31:0] instr, input logic [N-1:0] r1,
                                   input logic [N-1:0] r2);
        exp_t e;
        int   imm;
        e.rd1 = r1;
        e.rd2 = r2;
        e.a3  = instr[19:16];
        imm   = int'(instr[15:0]);                 // default: zero-extended 16-bit
        case (instr[31:28])
            4'd1:  begin e.ctrl = 8'b0110_0000; imm = int'(instr[19:0]); if (imm >= 'h80000) imm -= 'h100000; end
            4'd4:  e.ctrl = 8'b1010_0001;
            4'd5:  e.ctrl = 8'b0010_0010;
            4'd8:  e.ctrl = 8'b1000_0000;
            4'd9:  begin e.ctrl = 8'b1010_0000; if (imm >= 'h8000) imm -= 'h10000; end
            4'd10: e.ctrl = 8'b1000_1000;
            4'd11: begin e.ctrl = 8'b1010_1000; if (imm >= 'h8000) imm -= 'h10000; end
            4'd12: e.ctrl = 8'b1001_0000;
            4'd13: e.ctrl = 8'b1001_1000;
            4'd14: e.ctrl = 8'b0000_1100;
            default: e.ctrl = 8'b0000_0000;
        endcase
        e.ext = N'(imm);
        return e;
    endfunction

    function automatic exp_t zeros();
        exp_t z;
        z.rd1 = '0; z.rd2 = '0; z.ext = '0; z.a3 = '0; z.ctrl = '0;
        return z;
    endfunction

    // Drive away from the edge, capture on the next rising edge, sample 1 time unit later.
    task automatic apply(input logic [31:0] instr, input logic [N-1:0] r1, input logic [N-1:0] r2);
        @(negedge CLK);
        Instr_i = instr;
        RD1_i   = r1;
        RD2_i   = r2;
        @(posedge CLK);
        #1;
    endtask

    vec_t vecs[$];

    function automatic vec_t mk(input string n, input logic [31:0] i, input logic [N-1:0] r1,
                                input logic [N-1:0] r2, input logic [N-1:0] ext,
                                input logic [3:0] a3, input logic [7:0] ctrl);
        vec_t v;
        v.name = n; v.instr = i; v.rd1 = r1; v.rd2 = r2;
        v.exp.rd1 = r1; v.exp.rd2 = r2; v.exp.ext = ext; v.exp.a3 = a3; v.exp.ctrl = ctrl;
        return v;
    endfunction

    initial begin
        exp_t e;

        vecs.push_back(mk("ADD",       32'h8123_0000, 32'd1, 32'd2, 32'h0000_0000, 4'd3, 8'b1000_0000));
        vecs.push_back(mk("ADDI_7",    32'h9104_0007, 32'd5, 32'd6, 32'h0000_0007, 4'd4, 8'b1010_0000));
        vecs.push_back(mk("ADDI_FFFF", 32'h9104_FFFF, 32'd5, 32'd6, 32'hFFFF_FFFF, 4'd4, 8'b1010_0000));
        vecs.push_back(mk("LDR_FFFF",  32'h4005_FFFF, 32'd7, 32'd8, 32'h0000_FFFF, 4'd5, 8'b1010_0001));
        vecs.push_back(mk("B_80000",   32'h1008_0000, 32'd9, 32'd3, 32'hFFF8_0000, 4'd8, 8'b0110_0000));
        vecs.push_back(mk("B_7FFFF",   32'h1007_FFFF, 32'd0, 32'd0, 32'h0007_FFFF, 4'd7, 8'b0110_0000));
        vecs.push_back(mk("CMP",       32'hE120_0000, 32'd4, 32'd4, 32'h0000_0000, 4'd0, 8'b0000_1100));
        vecs.push_back(mk("OP_1111",   32'hF123_ABCD, 32'hAA, 32'h55, 32'h0000_ABCD, 4'd3, 8'b0000_0000));
        vecs.push_back(mk("STR",       32'h5123_8001, 32'd1, 32'd2, 32'h0000_8001, 4'd3, 8'b0010_0010));
        vecs.push_back(mk("SUB",       32'hA123_0000, 32'd1, 32'd2, 32'h0000_0000, 4'd3, 8'b1000_1000));
        vecs.push_back(mk("SUBI_8000", 32'hB123_8000, 32'd1, 32'd2, 32'hFFFF_8000, 4'd3, 8'b1010_1000));
        vecs.push_back(mk("AND",       32'hC123_0000, 32'd1, 32'd2, 32'h0000_0000, 4'd3, 8'b1001_0000));
        vecs.push_back(mk("ORR",       32'hD123_0000, 32'd1, 32'd2, 32'h0000_0000, 4'd3, 8'b1001_1000));
        vecs.push_back(mk("OP_0110",   32'h6FFF_FFFF, 32'd1, 32'd2, 32'h0000_FFFF, 4'hF, 8'b0000_0000));

        // Reset state with inputs active and clock running
        Instr_i = 32'h8123_0007; RD1_i = 32'h1234; RD2_i = 32'h5678;
        repeat (2) @(posedge CLK);
        #1 check("reset_hold", zeros());
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK); #1;
        check("first_capture", model(32'h8123_0007, 32'h1234, 32'h5678));

        // Table-driven vectors
        foreach (vecs[i]) begin
            apply(vecs[i].instr, vecs[i].rd1, vecs[i].rd2);
            check(vecs[i].name, vecs[i].exp);
        end

        // Operand pass-through on NOP
        for (int k = 0; k < 15; k++) begin
            apply(32'h0, N'(k), '0);
            e = zeros(); e.rd1 = N'(k);
            check($sformatf("pass_rd1_%0d", k), e);
        end
        for (int k = 0; k < 15; k++) begin
            apply(32'h0, '0, N'(k));
            e = zeros(); e.rd2 = N'(k);
            check($sformatf("pass_rd2_%0d", k), e);
        end

        // Async reset mid-cycle with ADD loaded
        apply(32'h8123_0000, 32'd1, 32'd2);
        check("add_before_rst", model(32'h8123_0000, 32'd1, 32'd2));
        #2 RST = 1'b1;
        #1 check("rst_async", zeros());
        repeat (2) @(posedge CLK);
        #1 check("rst_held", zeros());
        @(negedge CLK);
        RST = 1'b0;
        Instr_i = 32'hC345_0000; RD1_i = 32'd11; RD2_i = 32'd22;
        #1 check("rst_release_no_edge", zeros());
        @(posedge CLK); #1;
        check("rst_first_after", model(32'hC345_0000, 32'd11, 32'd22));

        // Reset mid-stream: the in-flight instruction is discarded, not replayed
        @(negedge CLK);
        Instr_i = 32'h9104_0042; RD1_i = 32'd3; RD2_i = 32'd4;
        RST = 1'b1;
        @(negedge CLK);
        Instr_i = 32'h0000_0000; RD1_i = '0; RD2_i = '0;
        RST = 1'b0;
        @(posedge CLK); #1;
        check("rst_discard", zeros());

`ifdef ID_EX_FLUSH_EN
        // Flush bubble: only side-effect controls drop
        @(negedge CLK);
        Instr_i = 32'h4005_FFFF; RD1_i = 32'd7; RD2_i = 32'd8; Flush_i = 1'b1;
        @(posedge CLK); #1;
        e = model(32'h4005_FFFF, 32'd7, 32'd8);
        e.ctrl[7] = 1'b0;
        check("flush_ldr", e);
        @(negedge CLK); Flush_i = 1'b0;
`endif

        // Randomised against the model
        for (int t = 0; t < 300; t++) begin
            logic [31:0]  ri;
            logic [N-1:0] r1, r2;
            ri = $urandom; r1 = $urandom; r2 = $urandom;
            apply(ri, r1, r2);
            check($sformatf("rand_%0d_%h", t, ri), model(ri, r1, r2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
